// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared FSM state type and default timing constants for input_debouncer
package input_debouncer_pkg;
  typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;
  localparam int DB_TICK_DIV_DEF     = 50000;
  localparam int DB_STABLE_TICKS_DEF = 8;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one-bit debounce FSM with committed level and registered rise/fall pulses
//   clk, rst_n (async, active-low), tick (sample strobe), sync_bit (synchronised input),
//   rst_val (level under reset) -> data (debounced), rise/fall (one-cycle commit pulses)
module debounce_bit import input_debouncer_pkg::*; #(
  parameter int STABLE_TICKS = DB_STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync_bit,
  input  logic rst_val,
  output logic data,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
  db_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic data_n, diff, commit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= DB_STABLE;
      cnt   <= '0;
      data  <= rst_val;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      data  <= data_n;
      rise  <= commit & sync_bit;
      fall  <= commit & ~sync_bit;
    end
  // The entry cycle into PENDING never counts a tick; any return to agreement drops all credit.
  always_comb begin
    diff    = sync_bit != data;
    commit  = state == DB_PENDING && diff && tick && cnt == C_LAST;
    data_n  = commit ? sync_bit : data;
    state_n = state == DB_STABLE ? (diff ? DB_PENDING : DB_STABLE)
                                 : (!diff || commit ? DB_STABLE : DB_PENDING);
    cnt_n   = state == DB_STABLE || !diff || commit ? '0 : (tick ? cnt + 1'b1 : cnt);
  end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser, shared sample prescaler and per-bit debounce for a switch/key bank
//   iCLOCK (CLOCK_50 domain), inRESET (async, active-low), iRAW[WIDTH] raw levels
//   -> oDATA debounced level, oRISE/oFALL one-cycle commit pulses
//   INPUT_DEBOUNCER_SIM_FAST_EN: drops the prescaler and samples every cycle (simulation builds)
module input_debouncer import input_debouncer_pkg::*; #(
  parameter int               WIDTH        = 18,
  parameter int               TICK_DIV     = DB_TICK_DIV_DEF,
  parameter int               STABLE_TICKS = DB_STABLE_TICKS_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic [WIDTH-1:0] iRAW,
  output logic [WIDTH-1:0] oDATA,
  output logic [WIDTH-1:0] oRISE,
  output logic [WIDTH-1:0] oFALL
);
  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic tick;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      sync_q1 <= RESET_VAL;
      sync_q2 <= RESET_VAL;
    end else begin
      sync_q1 <= iRAW;
      sync_q2 <= sync_q1;
    end
`ifdef INPUT_DEBOUNCER_SIM_FAST_EN
  assign tick = 1'b1;
`else
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pcnt;
  // With TICK_DIV == 1 the counter sits at zero and tick stays high.
  assign tick = pcnt == P_LAST;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + 1'b1;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
      .clk      (iCLOCK),
      .rst_n    (inRESET),
      .tick     (tick),
      .sync_bit (sync_q2[i]),
      .rst_val  (RESET_VAL[i]),
      .data     (oDATA[i]),
      .rise     (oRISE[i]),
      .fall     (oFALL[i])
    );
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: table-driven and directed self-checking bench for input_debouncer
module tb_input_debouncer;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] raw, data, rise, fall;
  logic [3:0] prev, seen_rise, seen_fall;
  int checks = 0, failures = 0, n_rise2, n;

  typedef struct {
    logic [3:0] raw;
    int         cyc;
    logic [3:0] data;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;
  vec_t tbl[6];

  input_debouncer #(.WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(4'h0)) dut (
    .iCLOCK  (clk),
    .inRESET (rst_n),
    .iRAW    (raw),
    .oDATA   (data),
    .oRISE   (rise),
    .oFALL   (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock, sampled 1 ns after the edge; pulses are checked against the level history.
  task automatic step();
    @(posedge clk);
    #1;
    chk("rise_vs_level", rise, data & ~prev);
    chk("fall_vs_level", fall, ~data & prev);
    chk("rise_fall_excl", rise & fall, 4'b0000);
    seen_rise |= rise;
    seen_fall |= fall;
    if (rise[2]) n_rise2++;
    prev = data;
  endtask

  task automatic clear_seen();
    seen_rise = '0;
    seen_fall = '0;
    n_rise2 = 0;
  endtask

  task automatic wait_bit(input int b, input logic v, input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit && data[b] !== v) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    tbl[0] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0101, 20, 4'b0101, 4'b0101, 4'b0000};
    tbl[2] = '{4'b1111,  2, 4'b0101, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0101, 20, 4'b0101, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1010, 20, 4'b1010, 4'b1010, 4'b0101};
    tbl[5] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b1010};
    prev = 4'b0000;
    clear_seen();
    rst_n = 1'b0;
    raw = 4'hF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_data", data, 4'b0000);
      chk("reset_rise", rise, 4'b0000);
      chk("reset_fall", fall, 4'b0000);
    end
    raw = 4'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      raw = tbl[i].raw;
      clear_seen();
      repeat (tbl[i].cyc) step();
      chk($sformatf("tbl%0d_data", i), data, tbl[i].data);
      chk($sformatf("tbl%0d_rise", i), seen_rise, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), seen_fall, tbl[i].fall);
    end
`ifdef INPUT_DEBOUNCER_SIM_FAST_EN
    clear_seen();
    raw = 4'b1000;
    wait_bit(3, 1'b1, 20, n);
    chk_rng("fast_latency", n, 6, 6);
    chk("fast_rise", rise, 4'b1000);
    raw = 4'b0000;
    repeat (10) step();
    chk("fast_fall_back", data, 4'b0000);
    clear_seen();
    raw = 4'b1000;
    repeat (2) step();
    raw = 4'b0000;
    repeat (10) step();
    chk("fast_pulse_data", data, 4'b0000);
    chk("fast_pulse_rise", seen_rise, 4'b0000);
`else
    clear_seen();
    raw = 4'b0001;
    wait_bit(0, 1'b1, 40, n);
    chk_rng("clean_latency", n, 11, 15);
    chk("clean_rise", rise, 4'b0001);
    repeat (5) step();
    chk("clean_rise_once", seen_rise, 4'b0001);
    chk("clean_no_fall", seen_fall, 4'b0000);
    clear_seen();
    raw = 4'b0011;
    repeat (6) step();
    raw = 4'b0001;
    repeat (20) step();
    chk("glitch_data", data, 4'b0001);
    chk("glitch_rise", seen_rise, 4'b0000);
    chk("glitch_fall", seen_fall, 4'b0000);
    clear_seen();
    for (int t = 0; t < 10; t++) begin
      raw[2] = ~raw[2];
      repeat (3) step();
    end
    chk("bounce_hold", data, 4'b0001);
    raw[2] = 1'b1;
    wait_bit(2, 1'b1, 40, n);
    chk_rng("bounce_latency", n, 11, 15);
    repeat (10) step();
    chk_rng("bounce_one_rise", n_rise2, 1, 1);
    chk("bounce_no_fall", seen_fall, 4'b0000);
    raw = 4'b0011;
    repeat (20) step();
    chk("multi_settled", data, 4'b0011);
    raw = 4'b1100;
    n = 0;
    while (n < 40 && data === 4'b0011) begin
      step();
      n++;
    end
    chk("multi_data", data, 4'b1100);
    chk("multi_rise", rise, 4'b1100);
    chk("multi_fall", fall, 4'b0011);
    raw = 4'b0011;
    repeat (6) step();
    chk("midrst_pending", data, 4'b1100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_data", data, 4'b0000);
    chk("midrst_async_rise", rise, 4'b0000);
    chk("midrst_async_fall", fall, 4'b0000);
    prev = 4'b0000;
    repeat (3) step();
    rst_n = 1'b1;
    clear_seen();
    repeat (25) step();
    chk("midrst_recommit", data, 4'b0011);
    chk("midrst_rise", seen_rise, 4'b0011);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
